// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM encoding, MemOP size
// codes, byte-mask generation and alignment checking.
package ysyx_22050710_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // MemOP size codes; the low bit distinguishes signed/unsigned in the
    // execute stage and is irrelevant to lane handling here.
    localparam logic [2:0] MOP_B   = 3'b000;
    localparam logic [2:0] MOP_BU  = 3'b001;
    localparam logic [2:0] MOP_H   = 3'b010;
    localparam logic [2:0] MOP_HU  = 3'b011;
    localparam logic [2:0] MOP_W   = 3'b100;
    localparam logic [2:0] MOP_WU  = 3'b101;
    localparam logic [2:0] MOP_D   = 3'b110;
    localparam logic [2:0] MOP_INV = 3'b111;

    // Byte enables of an access placed at lane 0; invalid code yields none.
    function automatic logic [7:0] memop_to_bytemask(input logic [2:0] memop);
        logic [7:0] mask;
        case (memop)
            MOP_B, MOP_BU: mask = 8'h01;
            MOP_H, MOP_HU: mask = 8'h03;
            MOP_W, MOP_WU: mask = 8'h0F;
            MOP_D:         mask = 8'hFF;
            default:       mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Natural alignment check; the invalid code is never "aligned" so that
    // one flag covers both error causes detected at request time.
    function automatic logic is_aligned(input logic [2:0] memop, input logic [2:0] addr_lo);
        logic ok;
        case (memop)
            MOP_B, MOP_BU: ok = 1'b1;
            MOP_H, MOP_HU: ok = (addr_lo[0] == 1'b0);
            MOP_W, MOP_WU: ok = (addr_lo[1:0] == 2'b00);
            MOP_D:         ok = (addr_lo == 3'b000);
            MOP_INV:       ok = 1'b0;
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational byte-lane logic: write mask and lane-shifted store data for the
// bus, right-justified size-masked load data, and the request error flag.
module ysyx_22050710_lsu_align
    import ysyx_22050710_lsu_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] bus_rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_rj,
    output logic        misalign
);

    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [5:0]  shamt;

    assign byte_mask = memop_to_bytemask(memop);
    assign shamt     = {addr_lo, 3'b000};
    assign wmask     = byte_mask << addr_lo;
    assign wdata_sh  = wdata << shamt;
    assign rdata_rj  = (bus_rdata >> shamt) & bit_mask;
    assign misalign  = ~is_aligned(memop, addr_lo);

    // Expand the lane-0 byte mask to a 64-bit bit mask for load data.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
    end

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit: accepts one core request at a time, runs a valid/ready bus
// transaction with a response timeout, and returns right-justified load data.
module ysyx_22050710_lsu
    import ysyx_22050710_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_MemOP,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_wen,
    output logic [63:0] o_bus_addr,
    output logic [63:0] o_bus_wdata,
    output logic [7:0]  o_bus_wmask,
    input  logic        i_bus_rvalid,
    input  logic [63:0] i_bus_rdata,
    input  logic        i_bus_err
);

    // WAIT lasts at most TIMEOUT cycles: the counter starts at 0 on entry and
    // the timeout fires on the cycle it holds TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              wen_q;
    logic [2:0]        memop_q;
    logic [63:0]       addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;
    logic              err_q;

    logic [2:0]  sel_memop;
    logic [2:0]  sel_addr_lo;
    logic [7:0]  lane_wmask;
    logic [63:0] lane_wdata;
    logic [63:0] lane_rdata;
    logic        lane_misalign;

    // In IDLE the lane logic checks the incoming request; afterwards it works
    // on the captured copy so bus signals stay stable under backpressure.
    assign sel_memop   = (state == ST_IDLE) ? i_req_MemOP     : memop_q;
    assign sel_addr_lo = (state == ST_IDLE) ? i_req_addr[2:0] : addr_q[2:0];

    ysyx_22050710_lsu_align u_align (
        .memop     (sel_memop),
        .addr_lo   (sel_addr_lo),
        .wdata     (wdata_q),
        .bus_rdata (i_bus_rdata),
        .wmask     (lane_wmask),
        .wdata_sh  (lane_wdata),
        .rdata_rj  (lane_rdata),
        .misalign  (lane_misalign)
    );

    assign o_req_ready  = (state == ST_IDLE);
    assign o_bus_valid  = (state == ST_BUS);
    assign o_bus_wen    = (state == ST_BUS) && wen_q;
    assign o_bus_addr   = (state == ST_BUS) ? {addr_q[63:3], 3'b000} : 64'd0;
    assign o_bus_wdata  = (state == ST_BUS) ? lane_wdata : 64'd0;
    assign o_bus_wmask  = (state == ST_BUS && wen_q) ? lane_wmask : 8'd0;
    assign o_resp_valid = (state == ST_RESP);
    assign o_resp_rdata = (state == ST_RESP) ? rdata_q : 64'd0;
    assign o_resp_err   = (state == ST_RESP) && err_q;

    // Request/bus/response sequencing with captured request and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wen_q   <= 1'b0;
            memop_q <= 3'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        wen_q   <= i_req_wen;
                        memop_q <= i_req_MemOP;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        if (lane_misalign) begin
                            rdata_q <= 64'd0;
                            err_q   <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_bus_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (i_bus_rvalid) begin
                        rdata_q <= wen_q ? 64'd0 : lane_rdata;
                        err_q   <= i_bus_err;
                        state   <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= 64'd0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
